// File: rtl/mdu_sched.sv
// Sequencing controller for the shared multiply/divide unit: times mult/div ops,
// raises the D-stage stall and gates MDU starts and HI/LO moves against exceptions.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] E_mdu_op,
  input  logic       D_mdu_use,
  output logic       mdu_start,
  output logic [1:0] mdu_op_q,
  output logic       busy,
  output logic       done,
  output logic       hi_we,
  output logic       lo_we,
  output logic       stall,
  output logic       E_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    op_d, op_code;
  logic          is_md, is_mult, not_run, accept;

  assign is_md   = (E_mdu_op >= 4'd1) && (E_mdu_op <= 4'd4);
  assign is_mult = (E_mdu_op == 4'd1) || (E_mdu_op == 4'd2);
  assign not_run = (state != S_RUN);
  // An E-stage op arriving during RUN is illegal and silently ignored.
  assign accept  = is_md && !req && not_run;

  always_comb begin
    op_code = 2'd3;
    case (E_mdu_op)
      4'd1:    op_code = 2'd0;
      4'd2:    op_code = 2'd1;
      4'd3:    op_code = 2'd2;
      default: op_code = 2'd3;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = mdu_op_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = is_mult ? MULT_LD : DIV_LD;
          op_d    = op_code;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mdu_op_q <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      mdu_op_q <= op_d;
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign mdu_start = accept;
  assign hi_we     = (E_mdu_op == 4'd7) && !req && not_run;
  assign lo_we     = (E_mdu_op == 4'd8) && !req && not_run;
  assign stall     = D_mdu_use && (busy || mdu_start);
  assign E_clr     = stall;

endmodule
